// File: rtl/tqv_bus_pkg.sv
// Shared widths, size codes, FSM state type and read-data sizing for the
// TinyQV peripheral bus initiator.
package tqv_bus_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Zero-extends the low 8/16/32 bits of a peripheral read according to size.
    function automatic logic [DATA_W-1:0] size_mask(input logic [DATA_W-1:0] data,
                                                    input logic [1:0]        size);
        logic [DATA_W-1:0] res;
        res = '0;
        case (size)
            SZ_BYTE: res[7:0]  = data[7:0];
            SZ_HALF: res[15:0] = data[15:0];
            SZ_WORD: res       = data;
            default: res       = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tqv_bus_initiator.sv
// Initiator for the TinyQV peripheral bus: command in, one bus transaction, response out.
// Optional read timeout enabled by defining TQV_BUS_INITIATOR_TIMEOUT_EN.
module tqv_bus_initiator
    import tqv_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_size,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [1:0]        bus_write_n,
    output logic [1:0]        bus_read_n,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              timeout_hit;

`ifdef TQV_BUS_INITIATOR_TIMEOUT_EN
    logic [15:0] to_cnt_q;

    // Ready on the limit cycle still completes the read.
    assign timeout_hit = (to_cnt_q == 16'(TIMEOUT_CYCLES)) && !bus_ready;

    always_ff @(posedge clk) begin
        if (rst || state_q != ST_READ) begin
            to_cnt_q <= '0;
        end else if (!bus_ready) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_size == SZ_NONE) state_d = ST_RESP;
                    else if (cmd_write)      state_d = ST_WRITE;
                    else                     state_d = ST_READ;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_READ: begin
                if (bus_ready || timeout_hit) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            size_q  <= SZ_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        size_q  <= cmd_size;
                        rdata_q <= '0;
                        err_q   <= (cmd_size == SZ_NONE);
                    end
                end
                ST_READ: begin
                    if (bus_ready) begin
                        rdata_q <= size_mask(bus_rdata, size_q);
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are decoded from state and the latched size only, never from inputs.
    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign bus_address = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_write_n = (state_q == ST_WRITE) ? size_q : SZ_NONE;
    assign bus_read_n  = (state_q == ST_READ)  ? size_q : SZ_NONE;

endmodule
